// File: rtl/tanhx_out_collector_pkg.sv
// Shared activation package: result word width, FP32 field positions,
// drain FSM state encodings and a NaN classifier used at push time.
package tanhx_out_collector_pkg;

  localparam int DWIDTH_DEF = 32;

  // FP32 field positions
  localparam int EXP_MSB = 30;
  localparam int EXP_LSB = 23;
  localparam int MAN_MSB = 22;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } drain_state_e;

  // NaN: exponent all ones and a nonzero mantissa (infinity is not NaN)
  function automatic logic is_nan_fp32(input logic [DWIDTH_DEF-1:0] w);
    return (w[EXP_MSB:EXP_LSB] == '1) && (w[MAN_MSB:0] != '0);
  endfunction

endpackage : tanhx_out_collector_pkg

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO: storage, pointers and occupancy.
// The caller guarantees push only when not full (or full with a pop) and
// pop only when rvalid is high.
module sync_fifo_fwft #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     rvalid,
  output logic [$clog2(DEPTH):0]   level,
  output logic [$clog2(DEPTH):0]   level_next
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;

  // Next pointers and occupancy from this cycle's push/pop
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (which would infer a latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = (rd_ptr_q == LAST_IDX) ? '0 : rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Entry storage write port
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; the read side is gated by rvalid, so stale contents are never visible.
    if (!rst && push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rvalid     = (level_q != '0);
  assign rdata      = rvalid ? mem_q[rd_ptr_q] : '0;
  assign level      = level_q;
  assign level_next = level_d;

endmodule : sync_fifo_fwft

// File: rtl/tanhx_out_collector.sv
// Collects tanh engine results into a FWFT FIFO, tags each word with a NaN
// flag, reports backpressure (space_ok) upstream, tracks dropped results and
// pops, and runs a flush/drain handshake.
module tanhx_out_collector
  import tanhx_out_collector_pkg::*;
#(
  parameter int DWIDTH   = DWIDTH_DEF,
  parameter int DEPTH    = 8,
  parameter int PIPE_LAT = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [DWIDTH-1:0]        in_data,
  output logic                     space_ok,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [DWIDTH-1:0]        m_data,
  output logic                     m_nan,
  input  logic                     flush,
  output logic                     flush_done,
  output logic                     overflow,
  input  logic                     clr_ovf,
  output logic [$clog2(DEPTH):0]   level,
  output logic [15:0]              pop_count
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  logic              push, pop, drop, full;
  logic              fifo_valid;
  logic [DWIDTH:0]   wr_entry, rd_entry;
  logic [LW-1:0]     level_cur, level_next;

  logic              overflow_q, overflow_d;
  logic              space_ok_q, space_ok_d;
  logic [15:0]       pop_count_q, pop_count_d;
  drain_state_e      state_q, state_d;

  // A full FIFO still accepts a word when the head leaves in the same cycle
  assign full     = (level_cur == FULL_LEVEL);
  assign pop      = fifo_valid & m_ready;
  assign push     = in_valid & (~full | pop);
  assign drop     = in_valid & full & ~pop;
  assign wr_entry = {is_nan_fp32(in_data), in_data};

  sync_fifo_fwft #(
    .WIDTH (DWIDTH + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .pop        (pop),
    .wdata      (wr_entry),
    .rdata      (rd_entry),
    .rvalid     (fifo_valid),
    .level      (level_cur),
    .level_next (level_next)
  );

  // Status: sticky overflow, pop counter, and space_ok from post-update occupancy
  always_comb begin
    overflow_d  = overflow_q;
    pop_count_d = pop_count_q;
    space_ok_d  = (int'(level_next) + PIPE_LAT + 1) <= DEPTH;
    if (drop)         overflow_d = 1'b1;
    else if (clr_ovf) overflow_d = 1'b0;
    if (pop)          pop_count_d = pop_count_q + 16'd1;
  end

  // Drain FSM next state: flush is only honoured from IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (flush) state_d = ST_DRAIN;
      ST_DRAIN: if ((level_cur == '0) && !push) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Status and FSM registers
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      space_ok_q  <= 1'b1;
      pop_count_q <= '0;
      state_q     <= ST_IDLE;
    end else begin
      overflow_q  <= overflow_d;
      space_ok_q  <= space_ok_d;
      pop_count_q <= pop_count_d;
      state_q     <= state_d;
    end
  end

  assign m_valid    = fifo_valid;
  assign m_data     = rd_entry[DWIDTH-1:0];
  assign m_nan      = rd_entry[DWIDTH];
  assign space_ok   = space_ok_q;
  assign overflow   = overflow_q;
  assign pop_count  = pop_count_q;
  assign level      = level_cur;
  assign flush_done = (state_q == ST_DONE);

endmodule : tanhx_out_collector

// File: tb/tb_tanhx_out_collector.sv
// Self-checking bench for tanhx_out_collector: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_tanhx_out_collector;

  localparam int DEPTH    = 8;
  localparam int PIPE_LAT = 3;

  logic        clk = 1'b0;
  logic        rst, in_valid, m_ready, flush, clr_ovf;
  logic [31:0] in_data;
  logic        space_ok, m_valid, m_nan, flush_done, overflow;
  logic [31:0] m_data;
  logic [3:0]  level;
  logic [15:0] pop_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [31:0] mq[$];
  bit          mdl_ovf;
  int          mdl_popcnt;
  bit          mdl_space;
  int          mdl_phase;   // 0 idle, 1 draining, 2 done

  always #5 clk = ~clk;

  tanhx_out_collector #(.DWIDTH(32), .DEPTH(DEPTH), .PIPE_LAT(PIPE_LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .space_ok   (space_ok),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_nan      (m_nan),
    .flush      (flush),
    .flush_done (flush_done),
    .overflow   (overflow),
    .clr_ovf    (clr_ovf),
    .level      (level),
    .pop_count  (pop_count)
  );

  function automatic bit word_is_nan(input logic [31:0] w);
    return (w[30:23] == 8'hFF) && (w[22:0] != 23'd0);
  endfunction

  // Drive one cycle of inputs, advance the model across the edge, settle
  task automatic step(input bit v, input logic [31:0] d, input bit rdy,
                      input bit fl, input bit clr, input bit r);
    int  lvl;
    bit  p_pop, p_push;
    rst = r; in_valid = v; in_data = d; m_ready = rdy; flush = fl; clr_ovf = clr;
    @(posedge clk);
    if (r) begin
      mq.delete();
      mdl_ovf = 0; mdl_popcnt = 0; mdl_space = 1; mdl_phase = 0;
    end else begin
      lvl    = mq.size();
      p_pop  = (lvl > 0) && rdy;
      p_push = v && ((lvl < DEPTH) || p_pop);
      case (mdl_phase)
        0: if (fl) mdl_phase = 1;
        1: if (lvl == 0 && !p_push) mdl_phase = 2;
        default: mdl_phase = 0;
      endcase
      if (p_pop) begin
        void'(mq.pop_front());
        mdl_popcnt = (mdl_popcnt + 1) % 65536;
      end
      if (p_push) mq.push_back(d);
      if (v && !p_push) mdl_ovf = 1;
      else if (clr)     mdl_ovf = 0;
      mdl_space = (mq.size() + PIPE_LAT + 1) <= DEPTH;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 32'd0, 0, 0, 0, 0);
  endtask

  task automatic test_reset;
    step(0, 32'd0, 0, 0, 0, 1);
    step(0, 32'd0, 0, 0, 0, 1);
    n_checks++; if (level !== 4'd0)      begin n_fail++; $display("FAIL reset_level: got %0d want 0", level); end
    n_checks++; if (m_valid !== 1'b0)    begin n_fail++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
    n_checks++; if (space_ok !== 1'b1)   begin n_fail++; $display("FAIL reset_space_ok: got %b want 1", space_ok); end
    n_checks++; if (overflow !== 1'b0)   begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    n_checks++; if (flush_done !== 1'b0) begin n_fail++; $display("FAIL reset_flush_done: got %b want 0", flush_done); end
    n_checks++; if (pop_count !== 16'd0) begin n_fail++; $display("FAIL reset_pop_count: got %0d want 0", pop_count); end
    n_checks++; if (m_data !== 32'd0)    begin n_fail++; $display("FAIL reset_m_data: got %h want 0", m_data); end
  endtask

  task automatic test_single_push;
    step(0, 32'd0, 0, 0, 0, 1);
    step(1, 32'h3F3EEC66, 1, 0, 0, 0);
    n_checks++; if (m_valid !== 1'b1)        begin n_fail++; $display("FAIL single_valid: got %b want 1", m_valid); end
    n_checks++; if (m_data !== 32'h3F3EEC66) begin n_fail++; $display("FAIL single_data: got %h want 3f3eec66", m_data); end
    n_checks++; if (m_nan !== 1'b0)          begin n_fail++; $display("FAIL single_nan: got %b want 0", m_nan); end
    step(0, 32'd0, 1, 0, 0, 0);
    n_checks++; if (m_valid !== 1'b0)        begin n_fail++; $display("FAIL single_valid_drop: got %b want 0", m_valid); end
    n_checks++; if (pop_count !== 16'd1)     begin n_fail++; $display("FAIL single_pop_count: got %0d want 1", pop_count); end
  endtask

  task automatic test_fill_overflow;
    logic [31:0] words[10];
    int          exp_lvl;
    step(0, 32'd0, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) begin
      words[i] = $urandom() & 32'h3FFF_FFFF;
      step(1, words[i], 0, 0, 0, 0);
      exp_lvl = (i + 1 > DEPTH) ? DEPTH : i + 1;
      n_checks++; if (level !== 4'(exp_lvl))            begin n_fail++; $display("FAIL fill_level[%0d]: got %0d want %0d", i, level, exp_lvl); end
      n_checks++; if (space_ok !== (exp_lvl <= 4))      begin n_fail++; $display("FAIL fill_space_ok[%0d]: got %b want %b", i, space_ok, exp_lvl <= 4); end
      n_checks++; if (overflow !== (i >= DEPTH))        begin n_fail++; $display("FAIL fill_overflow[%0d]: got %b want %b", i, overflow, i >= DEPTH); end
    end
    for (int i = 0; i < DEPTH; i++) begin
      n_checks++; if (m_data !== words[i]) begin n_fail++; $display("FAIL fill_order[%0d]: got %h want %h", i, m_data, words[i]); end
      step(0, 32'd0, 1, 0, 0, 0);
    end
    n_checks++; if (level !== 4'd0)     begin n_fail++; $display("FAIL fill_drained: got %0d want 0", level); end
    n_checks++; if (overflow !== 1'b1)  begin n_fail++; $display("FAIL fill_ovf_sticky: got %b want 1", overflow); end
    step(0, 32'd0, 0, 0, 1, 0);
    n_checks++; if (overflow !== 1'b0)  begin n_fail++; $display("FAIL fill_ovf_clear: got %b want 0", overflow); end
  endtask

  task automatic test_full_push_pop;
    logic [31:0] words[DEPTH];
    logic [31:0] new_word;
    step(0, 32'd0, 0, 0, 0, 1);
    for (int i = 0; i < DEPTH; i++) begin
      words[i] = 32'h1000_0000 + 32'(i);
      step(1, words[i], 0, 0, 0, 0);
    end
    new_word = 32'h3ABC_DEF0;
    step(1, new_word, 1, 0, 1, 0);
    n_checks++; if (level !== 4'd8)     begin n_fail++; $display("FAIL fullpp_level: got %0d want 8", level); end
    n_checks++; if (overflow !== 1'b0)  begin n_fail++; $display("FAIL fullpp_overflow: got %b want 0", overflow); end
    for (int i = 1; i < DEPTH; i++) begin
      n_checks++; if (m_data !== words[i]) begin n_fail++; $display("FAIL fullpp_order[%0d]: got %h want %h", i, m_data, words[i]); end
      step(0, 32'd0, 1, 0, 0, 0);
    end
    n_checks++; if (m_data !== new_word) begin n_fail++; $display("FAIL fullpp_last: got %h want %h", m_data, new_word); end
    step(0, 32'd0, 1, 0, 0, 0);
    n_checks++; if (m_valid !== 1'b0)    begin n_fail++; $display("FAIL fullpp_empty: got %b want 0", m_valid); end
  endtask

  task automatic test_nan;
    step(0, 32'd0, 0, 0, 0, 1);
    step(1, 32'h7FC00001, 0, 0, 0, 0);
    n_checks++; if (m_nan !== 1'b1) begin n_fail++; $display("FAIL nan_qnan: got %b want 1", m_nan); end
    step(1, 32'h7F800000, 1, 0, 0, 0);
    n_checks++; if (m_nan !== 1'b0) begin n_fail++; $display("FAIL nan_inf: got %b want 0", m_nan); end
    n_checks++; if (m_data !== 32'h7F800000) begin n_fail++; $display("FAIL nan_inf_data: got %h want 7f800000", m_data); end
    step(0, 32'd0, 1, 0, 0, 0);
  endtask

  task automatic test_flush;
    int done_at, pulses;
    step(0, 32'd0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 32'h2000_0000 + 32'(i), 0, 0, 0, 0);
    step(0, 32'd0, 1, 1, 0, 0);                 // flush at level 3
    done_at = -1; pulses = 0;
    for (int c = 1; c <= 12; c++) begin
      step(0, 32'd0, 1, (c == 1), 0, 0);        // second flush lands in DRAIN
      if (flush_done === 1'b1) begin
        pulses++;
        if (done_at < 0) done_at = c;
      end
    end
    n_checks++; if (done_at !== 3) begin n_fail++; $display("FAIL flush_timing: got %0d edges after flush edge want 3", done_at); end
    n_checks++; if (pulses !== 1)  begin n_fail++; $display("FAIL flush_pulses: got %0d want 1", pulses); end
    n_checks++; if (level !== 4'd0) begin n_fail++; $display("FAIL flush_level: got %0d want 0", level); end
  endtask

  task automatic test_reset_midstream;
    step(0, 32'd0, 0, 0, 0, 1);
    for (int i = 0; i < 9; i++) step(1, 32'h0100_0000 + 32'(i), 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 32'd0, 1, 0, 0, 0);
    n_checks++; if (level !== 4'd5 || overflow !== 1'b1) begin n_fail++; $display("FAIL midrst_setup: got level %0d ovf %b want 5/1", level, overflow); end
    step(1, 32'h0BAD_0BAD, 1, 1, 1, 1);
    n_checks++; if (level !== 4'd0)     begin n_fail++; $display("FAIL midrst_level: got %0d want 0", level); end
    n_checks++; if (m_valid !== 1'b0)   begin n_fail++; $display("FAIL midrst_valid: got %b want 0", m_valid); end
    n_checks++; if (space_ok !== 1'b1)  begin n_fail++; $display("FAIL midrst_space_ok: got %b want 1", space_ok); end
    n_checks++; if (overflow !== 1'b0)  begin n_fail++; $display("FAIL midrst_overflow: got %b want 0", overflow); end
    step(0, 32'd0, 0, 0, 0, 0);
    n_checks++; if (flush_done !== 1'b0 || level !== 4'd0) begin n_fail++; $display("FAIL midrst_after: got done %b level %0d want 0/0", flush_done, level); end
  endtask

  task automatic test_random;
    logic [31:0] d, exp_data;
    bit          exp_nan;
    step(0, 32'd0, 0, 0, 0, 1);
    for (int c = 0; c < 600; c++) begin
      d = $urandom();
      if ($urandom_range(0, 7) == 0) d = {d[31], 8'hFF, d[22:0]};
      step($urandom_range(0, 3) != 0, d, $urandom_range(0, 2) == 0,
           $urandom_range(0, 40) == 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 250) == 0);
      exp_data = (mq.size() > 0) ? mq[0] : 32'd0;
      exp_nan  = (mq.size() > 0) ? word_is_nan(mq[0]) : 1'b0;
      n_checks++; if (level !== 4'(mq.size()))        begin n_fail++; $display("FAIL rnd_level@%0d: got %0d want %0d", c, level, mq.size()); end
      n_checks++; if (m_valid !== (mq.size() > 0))    begin n_fail++; $display("FAIL rnd_valid@%0d: got %b want %b", c, m_valid, mq.size() > 0); end
      n_checks++; if (m_data !== exp_data)            begin n_fail++; $display("FAIL rnd_data@%0d: got %h want %h", c, m_data, exp_data); end
      n_checks++; if (m_nan !== exp_nan)              begin n_fail++; $display("FAIL rnd_nan@%0d: got %b want %b", c, m_nan, exp_nan); end
      n_checks++; if (space_ok !== mdl_space)         begin n_fail++; $display("FAIL rnd_space_ok@%0d: got %b want %b", c, space_ok, mdl_space); end
      n_checks++; if (overflow !== mdl_ovf)           begin n_fail++; $display("FAIL rnd_overflow@%0d: got %b want %b", c, overflow, mdl_ovf); end
      n_checks++; if (flush_done !== (mdl_phase == 2)) begin n_fail++; $display("FAIL rnd_flush_done@%0d: got %b want %b", c, flush_done, mdl_phase == 2); end
      n_checks++; if (pop_count !== 16'(mdl_popcnt)) begin n_fail++; $display("FAIL rnd_pop_count@%0d: got %0d want %0d", c, pop_count, mdl_popcnt); end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; m_ready = 1'b0; flush = 1'b0; clr_ovf = 1'b0;
    test_reset();
    test_single_push();
    test_fill_overflow();
    test_full_push_pop();
    test_nan();
    test_flush();
    test_reset_midstream();
    test_random();
    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_tanhx_out_collector
